// File: rtl/acc_pkg.sv
// ---------------------------------------------------------------------------
// acc_pkg: width helpers and input-side FSM state for tiled_channel_accumulator
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package acc_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  function automatic int calc_bit_pe(input int ifm_bit, input int w_bit,
                                     input int k, input int ch_per_tile);
    return ifm_bit + w_bit + $clog2(k * ch_per_tile);
  endfunction

  // Wide enough that TILES beats of K full-scale lanes can never wrap.
  function automatic int calc_bit_acc(input int ifm_bit, input int w_bit,
                                      input int k, input int ch_per_tile,
                                      input int tiles);
    return ifm_bit + w_bit + $clog2(k * k * ch_per_tile * tiles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_sum_stage.sv
// ---------------------------------------------------------------------------
// pe_sum_stage: sign-extending K-lane adder with a holdable stage-1 register
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pe_sum_stage
  import acc_pkg::*;
#(
  parameter int K       = 3,
  parameter int BIT_PE  = 25,
  parameter int BIT_ACC = 29
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      adv,
  input  logic                      load,
  input  logic [K*BIT_PE-1:0]       pe,
  input  logic                      first,
  input  logic                      last,
  output logic                      s1_valid,
  output logic                      s1_first,
  output logic                      s1_last,
  output logic signed [BIT_ACC-1:0] s1_sum
);

  logic signed [BIT_ACC-1:0] lane_ext [K];
  logic signed [BIT_ACC-1:0] sum_comb;

  for (genvar i = 0; i < K; i++) begin : g_lane
    assign lane_ext[i] = {{(BIT_ACC-BIT_PE){pe[i*BIT_PE+BIT_PE-1]}},
                          pe[i*BIT_PE +: BIT_PE]};
  end

  always_comb begin
    sum_comb = '0;
    for (int i = 0; i < K; i++) begin
      sum_comb = sum_comb + lane_ext[i];
    end
  end

  // When adv is low the whole register holds so a stalled beat is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= load;
      if (load) begin
        s1_sum   <= sum_comb;
        s1_first <= first;
        s1_last  <= last;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tiled_channel_accumulator.sv
// ---------------------------------------------------------------------------
// tiled_channel_accumulator: sums K PE lanes per beat, accumulates TILES beats
// into one result with optional ReLU, valid/ready output. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tiled_channel_accumulator
  import acc_pkg::*;
#(
  parameter int IFM_BIT     = 8,
  parameter int W_BIT       = 8,
  parameter int K           = 3,
  parameter int CH_PER_TILE = 128,
  parameter int TILES       = 4,
  localparam int BIT_PE     = calc_bit_pe(IFM_BIT, W_BIT, K, CH_PER_TILE),
  localparam int BIT_ACC    = calc_bit_acc(IFM_BIT, W_BIT, K, CH_PER_TILE, TILES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      relu_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [K*BIT_PE-1:0]       PE,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [BIT_ACC-1:0] out_data
);

  localparam int CNT_W = (TILES > 1) ? $clog2(TILES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILES - 1);

  logic                      adv;
  logic                      accept;
  logic [CNT_W-1:0]          beat_cnt;
  logic                      beat_first;
  logic                      beat_last;
  acc_state_e                state;
  acc_state_e                state_nxt;
  logic                      relu_grp;
  logic                      s1_valid;
  logic                      s1_first;
  logic                      s1_last;
  logic signed [BIT_ACC-1:0] s1_sum;
  logic signed [BIT_ACC-1:0] acc;
  logic signed [BIT_ACC-1:0] nxt;

  // Single advance enable: a blocked output stalls every stage at once.
  assign adv        = !(out_valid && !out_ready) && !flush;
  assign in_ready   = adv;
  assign accept     = in_valid && adv;
  assign beat_first = (beat_cnt == '0);
  assign beat_last  = (beat_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (flush) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_last ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    if (!beat_last) state_nxt = ACCUM;
        ACCUM:   if (beat_last)  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The group's ReLU mode is fixed by its opening beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relu_grp <= 1'b0;
    end else if (accept && (state == IDLE)) begin
      relu_grp <= relu_en;
    end
  end

  pe_sum_stage #(
    .K       (K),
    .BIT_PE  (BIT_PE),
    .BIT_ACC (BIT_ACC)
  ) u_pe_sum_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .adv      (adv),
    .load     (accept),
    .pe       (PE),
    .first    (beat_first),
    .last     (beat_last),
    .s1_valid (s1_valid),
    .s1_first (s1_first),
    .s1_last  (s1_last),
    .s1_sum   (s1_sum)
  );

  assign nxt = s1_first ? s1_sum : acc + s1_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (adv && s1_valid) begin
        if (s1_last) begin
          out_data  <= (relu_grp && nxt[BIT_ACC-1]) ? '0 : nxt;
          out_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= nxt;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tiled_channel_accumulator.sv
// ---------------------------------------------------------------------------
// tb_tiled_channel_accumulator: directed stimulus with a queue scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tiled_channel_accumulator;

  localparam int IFM_BIT     = 8;
  localparam int W_BIT       = 8;
  localparam int K           = 3;
  localparam int CH_PER_TILE = 128;
  localparam int TILES       = 4;
  localparam int BIT_PE      = IFM_BIT + W_BIT + $clog2(K * CH_PER_TILE);
  localparam int BIT_ACC     = IFM_BIT + W_BIT + $clog2(K * K * CH_PER_TILE * TILES);
  localparam int MAX_PE      = (1 << (BIT_PE - 1)) - 1;

  logic                      clk;
  logic                      rst_n;
  logic                      flush;
  logic                      relu_en;
  logic                      in_valid;
  logic                      in_ready;
  logic [K*BIT_PE-1:0]       pe;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [BIT_ACC-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int w;
  int n0;
  logic signed [BIT_ACC-1:0] exp_q [$];
  int                        out_cyc [$];

  tiled_channel_accumulator #(
    .IFM_BIT     (IFM_BIT),
    .W_BIT       (W_BIT),
    .K           (K),
    .CH_PER_TILE (CH_PER_TILE),
    .TILES       (TILES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .PE        (pe),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Output monitor: every handshake pops one expected result.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0d expected none", out_data);
      end else begin
        logic signed [BIT_ACC-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_data: got %0d expected %0d", out_data, e);
        end
      end
      out_cyc.push_back(cyc);
    end
  end

  // Present one beat at a negedge and hold it until accepted.
  task automatic send(input int a, input int b, input int c, input bit relu,
                      output int waited);
    waited = 0;
    @(negedge clk);
    pe       = {BIT_PE'(c), BIT_PE'(b), BIT_PE'(a)};
    relu_en  = relu;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    relu_en   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pe        = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic group and latency
    exp_q.push_back(24);
    for (int i = 0; i < 4; i++) send(1, 2, 3, 1'b0, w);
    chk("lat_before", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 24);
    @(posedge clk);
    #1;
    chk("one_cycle_valid", out_valid, 0);

    // Negative sum without and with ReLU
    exp_q.push_back(-60);
    for (int i = 0; i < 4; i++) send(-5, -5, -5, 1'b0, w);
    exp_q.push_back(0);
    for (int i = 0; i < 4; i++) send(-5, -5, -5, 1'b1, w);
    drain();

    // Output back-pressure
    out_ready = 1'b0;
    exp_q.push_back(24);
    for (int i = 0; i < 4; i++) send(1, 2, 3, 1'b0, w);
    @(posedge clk);
    #1;
    chk("stall_valid", out_valid, 1);
    @(negedge clk);
    pe       = {BIT_PE'(9), BIT_PE'(9), BIT_PE'(9)};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_data", out_data, 24);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release", out_valid, 0);

    // Back-to-back groups at full rate
    n0 = out_cyc.size();
    exp_q.push_back(12);
    exp_q.push_back(24);
    exp_q.push_back(36);
    for (int g = 1; g <= 3; g++) begin
      for (int i = 0; i < 4; i++) begin
        send(g, g, g, 1'b0, w);
        chk("b2b_no_stall", w, 0);
      end
    end
    drain();
    if (out_cyc.size() >= n0 + 3) begin
      chk("b2b_gap1", out_cyc[n0+1] - out_cyc[n0], 4);
      chk("b2b_gap2", out_cyc[n0+2] - out_cyc[n0+1], 4);
    end else begin
      chk("b2b_count", out_cyc.size() - n0, 3);
    end

    // Flush discards a partial group
    exp_q.push_back(12);
    for (int i = 0; i < 2; i++) send(7, 7, 7, 1'b0, w);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    pe       = {BIT_PE'(9), BIT_PE'(9), BIT_PE'(9)};
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) send(1, 1, 1, 1'b0, w);
    drain();
    chk("pending_before_reset", exp_q.size(), 0);

    // Asynchronous reset mid-group
    for (int i = 0; i < 3; i++) send(1, 1, 1, 1'b0, w);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4);
    for (int i = 0; i < 4; i++) send(1, 0, 0, 1'b0, w);
    drain();

    // Full-scale positive lanes must not wrap
    exp_q.push_back(201326580);
    for (int i = 0; i < 4; i++) send(MAX_PE, MAX_PE, MAX_PE, 1'b0, w);
    drain();
    chk("pending_at_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
